// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and state encoding for the matrix MAC engine
//
// Purpose: FSM state constants, default operand/accumulator widths and signed
// element typedefs shared by matrix_mac_engine and mac_unit.
// Ports: none (package).

package matrix_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int ACC_WIDTH      = 2 * DEF_DATA_WIDTH;

  typedef logic signed [DEF_DATA_WIDTH-1:0] elem_t;
  typedef logic signed [ACC_WIDTH-1:0]      acc_t;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply with load/accumulate register
//
// Purpose: acc <= a*b (load) or acc + a*b (accumulate) when en is high;
// the sum wraps modulo 2^(2*DATA_WIDTH).
// Ports:
//   clk, rst  clock, asynchronous active-high reset (acc cleared)
//   en        update acc this cycle
//   load      replace acc with the product instead of adding to it
//   a, b      signed DATA_WIDTH operands
//   acc       signed 2*DATA_WIDTH accumulator

module mac_unit
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           load,
  input  logic signed [DATA_WIDTH-1:0]   a,
  input  logic signed [DATA_WIDTH-1:0]   b,
  output logic signed [2*DATA_WIDTH-1:0] acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  // Size casts keep signedness, so operands are sign-extended before the multiply.
  assign prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= load ? prod : acc + prod;
    end
  end

endmodule

// File: rtl/matrix_mac_engine.sv
// rtl/matrix_mac_engine.sv - sequential signed matrix multiplier C = A*B
//
// Purpose: holds A (MxN) and B (NxP) storage, runs one MAC per clock and
// emits C row-major over a valid/ready handshake, pulsing done at the end.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   a_wen/a_addr/a_data      A element write (row-major r*N+k), idle only
//   b_wen/b_addr/b_data      B element write (row-major k*P+c), idle only
//   start                    begin computation (honoured in IDLE only)
//   busy                     high in every state except IDLE
//   result_data/row/col      current C element and its position
//   result_valid/ready       output handshake
//   done                     one-cycle pulse after the last transfer

module matrix_mac_engine
  import matrix_pkg::*;
#(
  parameter int M          = 3,
  parameter int N          = 3,
  parameter int P          = 3,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           a_wen,
  input  logic [$clog2(M*N)-1:0]         a_addr,
  input  logic signed [DATA_WIDTH-1:0]   a_data,
  input  logic                           b_wen,
  input  logic [$clog2(N*P)-1:0]         b_addr,
  input  logic signed [DATA_WIDTH-1:0]   b_data,
  input  logic                           start,
  output logic                           busy,
  output logic signed [2*DATA_WIDTH-1:0] result_data,
  output logic [$clog2(M)-1:0]           result_row,
  output logic [$clog2(P)-1:0]           result_col,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic                           done
);

  localparam int A_SIZE = M * N;
  localparam int B_SIZE = N * P;
  localparam int AW     = $clog2(A_SIZE);
  localparam int BW     = $clog2(B_SIZE);
  localparam int RW     = $clog2(M);
  localparam int CW     = $clog2(P);
  localparam int KW     = (N > 1) ? $clog2(N) : 1;

  logic signed [DATA_WIDTH-1:0] a_mem [A_SIZE];
  logic signed [DATA_WIDTH-1:0] b_mem [B_SIZE];

  state_t        state;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [KW-1:0] k;
  logic [AW-1:0] a_idx;
  logic [BW-1:0] b_idx;
  logic          last_k;
  logic          last_elem;

  assign busy         = (state != ST_IDLE);
  assign result_valid = (state == ST_EMIT);
  assign done         = (state == ST_DONE);
  assign result_row   = r;
  assign result_col   = c;

  assign a_idx     = AW'(32'(r) * N + 32'(k));
  assign b_idx     = BW'(32'(k) * P + 32'(c));
  assign last_k    = (k == KW'(N - 1));
  assign last_elem = (r == RW'(M - 1)) && (c == CW'(P - 1));

  // Storage writes are only honoured while idle so a running product never
  // sees its operands change underneath it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < A_SIZE; i++) a_mem[i] <= '0;
      for (int i = 0; i < B_SIZE; i++) b_mem[i] <= '0;
    end else if (!busy) begin
      if (a_wen && (32'(a_addr) < A_SIZE)) a_mem[a_addr] <= a_data;
      if (b_wen && (32'(b_addr) < B_SIZE)) b_mem[b_addr] <= b_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      r     <= '0;
      c     <= '0;
      k     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_MAC;
            r     <= '0;
            c     <= '0;
            k     <= '0;
          end
        end
        ST_MAC: begin
          if (last_k) begin
            k     <= '0;
            state <= ST_EMIT;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_EMIT: begin
          if (result_ready) begin
            if (last_elem) begin
              state <= ST_DONE;
            end else begin
              if (c == CW'(P - 1)) begin
                c <= '0;
                r <= r + 1'b1;
              end else begin
                c <= c + 1'b1;
              end
              state <= ST_MAC;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // k==0 marks the first MAC of a dot product, so the accumulator is loaded
  // rather than added to and no previous element leaks in.
  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_MAC),
    .load (k == '0),
    .a    (a_mem[a_idx]),
    .b    (b_mem[b_idx]),
    .acc  (result_data)
  );

endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb/tb_matrix_mac_engine.sv - directed scoreboard bench for matrix_mac_engine

module tb_matrix_mac_engine;

  localparam int M = 3;
  localparam int N = 3;
  localparam int P = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_wen, b_wen, start, result_ready;
  logic [3:0]        a_addr, b_addr;
  logic signed [7:0] a_data, b_data;
  logic              busy, result_valid, done;
  logic [15:0]       result_data;
  logic [1:0]        result_row, result_col;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          row;
    int          col;
    logic [15:0] data;
  } res_t;

  res_t        exp_q[$];
  logic [15:0] got_q[$];
  int          sa[9];
  int          sb[9];

  always #5 clk = ~clk;

  matrix_mac_engine #(.M(M), .N(N), .P(P), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_wen        (a_wen),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .b_wen        (b_wen),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .start        (start),
    .busy         (busy),
    .result_data  (result_data),
    .result_row   (result_row),
    .result_col   (result_col),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Writes all nine A and B elements in the same cycles; optionally raises
  // start together with the final write.
  task automatic load_mats(input int av[9], input int bv[9], input bit start_on_last);
    for (int i = 0; i < 9; i++) begin
      a_wen  = 1'b1; a_addr = 4'(i); a_data = 8'(av[i]);
      b_wen  = 1'b1; b_addr = 4'(i); b_data = 8'(bv[i]);
      start  = (start_on_last && i == 8);
      @(negedge clk);
    end
    a_wen = 1'b0; b_wen = 1'b0; start = 1'b0;
    sa = av;
    sb = bv;
  endtask

  task automatic push_model();
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < P; c++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += sa[r*N+k] * sb[k*P+c];
        exp_q.push_back('{row: r, col: c, data: 16'(s)});
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called one negedge after the start edge (edge count e = 1).
  task automatic collect(input int n, input int stall_elem, input bit disturb, input bit chk_timing);
    int   e       = 1;
    int   got     = 0;
    int   first_e = -1;
    int   stall   = stall_elem;
    bit   fin     = 1'b0;
    res_t x;
    got_q.delete();
    while (!fin && e < 600) begin
      if (disturb && e == 2) begin
        start = 1'b1; a_wen = 1'b1; a_addr = 4'd0; a_data = 8'sd99;
      end else if (disturb && e == 3) begin
        start = 1'b0; a_wen = 1'b0;
      end
      if (got == n) begin
        chk("done_pulse", done, 1);
        if (chk_timing) chk("start_to_done_cycles", e, M*P*(N+1)+1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        fin = 1'b1;
      end else if (result_valid) begin
        if (first_e < 0) begin
          first_e = e;
          if (chk_timing) chk("first_valid_latency", e, N+1);
        end
        if (got == stall) begin
          result_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            e++;
            chk("stall_valid", result_valid, 1);
            chk("stall_data", result_data, exp_q[0].data);
            chk("stall_row", result_row, exp_q[0].row);
            chk("stall_col", result_col, exp_q[0].col);
          end
          result_ready = 1'b1;
          stall = -1;
        end
        x = exp_q.pop_front();
        chk("res_row", result_row, x.row);
        chk("res_col", result_col, x.col);
        chk("res_data", result_data, x.data);
        got_q.push_back(result_data);
        got++;
      end
      if (!fin) begin
        @(negedge clk);
        e++;
      end
    end
    chk("done_seen", fin, 1);
    chk("elements_transferred", got, n);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    a_wen = 1'b0; b_wen = 1'b0; start = 1'b0; result_ready = 1'b1;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_data", result_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Identity times 1..9
    load_mats('{1,0,0, 0,1,0, 0,0,1}, '{1,2,3, 4,5,6, 7,8,9}, 1'b0);
    push_model();
    do_start();
    collect(9, -1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) chk("identity_value", got_q[i], 32'(i + 1));

    // Mixed signs, start in same cycle as last write
    load_mats('{1,-2,3, 0,0,0, 0,0,0}, '{4,0,0, 5,0,0, -6,0,0}, 1'b1);
    push_model();
    collect(9, -1, 1'b0, 1'b1);
    chk("c00_neg24", got_q[0], 16'hFFE8);

    // All -128 wraps; stall 5 cycles on element 4
    load_mats('{-128,-128,-128, -128,-128,-128, -128,-128,-128},
              '{-128,-128,-128, -128,-128,-128, -128,-128,-128}, 1'b0);
    push_model();
    do_start();
    collect(9, 4, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) chk("wrap_c000", got_q[i], 16'hC000);

    // start and a_wen while busy are ignored; second run matches model
    load_mats('{2,-3,5, 7,-1,4, 0,6,-8}, '{-5,3,1, 2,9,-4, 6,-7,8}, 1'b0);
    push_model();
    do_start();
    collect(9, -1, 1'b1, 1'b0);
    @(negedge clk);
    chk("no_restart", busy, 0);
    push_model();
    do_start();
    collect(9, -1, 1'b0, 1'b1);

    // Reset mid-MAC aborts and clears storage
    do_start();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    chk("midrst_no_done", done, 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin sa[i] = 0; sb[i] = 0; end
    @(negedge clk);
    push_model();
    do_start();
    collect(9, -1, 1'b0, 1'b1);
    load_mats('{3,1,-2, 0,4,1, -1,2,5}, '{1,2,3, 4,5,6, 7,8,9}, 1'b0);
    push_model();
    do_start();
    collect(9, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
